// File: rtl/button_tx_pkg.sv
// rtl/button_tx_pkg.sv - shared constants, state type and frame word builder for button_tx_framer
//
// Contents:
//   MAGIC       - header tag carried in the upper byte of word 0
//   tx_state_t  - framer state encoding {IDLE, SEND, GAP}
//   frame_word  - builds one frame word (64-bit, caller truncates to its stream width)
package button_tx_pkg;

    localparam logic [7:0] MAGIC = 8'hB7;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } tx_state_t;

    // sent_flat carries pad i at bits [i*btn_w +: btn_w]; btn_w <= 56 so the
    // {pad index, buttons} field always fits in the 64-bit result.
    function automatic logic [63:0] frame_word(
        input int          w,
        input logic [7:0]  seq_v,
        input logic [255:0] sent_flat,
        input int          num_pads,
        input int          btn_w
    );
        logic [63:0] word;
        logic [63:0] mask;
        word = '0;
        mask = (64'd1 << btn_w) - 64'd1;
        if (w == 0) begin
            word = {48'd0, MAGIC, seq_v};
        end else if (w <= num_pads) begin
            word = (64'(8'(w - 1)) << btn_w)
                 | (64'(sent_flat >> ((w - 1) * btn_w)) & mask);
        end
        return word;
    endfunction

endpackage

// File: rtl/keepalive_timer.sv
// rtl/keepalive_timer.sv - idle-time counter that flags when a keepalive resend is due
//
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   run     in  count while high
//   clear   in  return the count to 0 (wins over run)
//   expire  out count has reached KEEPALIVE_CYCLES-1
// KEEPALIVE_CYCLES = 0 removes the counter and holds expire low.
module keepalive_timer #(
    parameter int KEEPALIVE_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    generate
        if (KEEPALIVE_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, run, clear};
            assign expire = 1'b0;
        end else begin : g_on
            localparam int KW = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
            localparam logic [KW-1:0] LAST = KW'(KEEPALIVE_CYCLES - 1);
            logic [KW-1:0] count;

            // Holds at LAST until cleared so expire stays asserted until the
            // framer actually leaves IDLE.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (run && count != LAST) begin
                    count <= count + 1'b1;
                end
            end

            assign expire = (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/button_tx_framer.sv
// rtl/button_tx_framer.sv - multi-pad button snapshot framer with keepalive and inter-frame gap
//
// Ports:
//   clk          in  single clock
//   rst_n        in  asynchronous active-low reset
//   pad_valid    in  [NUM_PADS]        per-pad strobe, matching pad_buttons slice is fresh
//   pad_buttons  in  [NUM_PADS*BTN_W]  pad i at [i*BTN_W +: BTN_W]
//   axiov        out frame word valid
//   axiod        out [DATA_SIZE] frame word, 0 when axiov is 0
//   seq          out [8]  sequence number of the current or last frame
//   frames_sent  out [16] wrapping count of completed frames
module button_tx_framer
    import button_tx_pkg::*;
#(
    parameter int NUM_PADS         = 2,
    parameter int BTN_W            = 8,
    parameter int DATA_SIZE        = 16,
    parameter int FRAME_WORDS      = 32,
    parameter int GAP_CYCLES       = 64,
    parameter int KEEPALIVE_CYCLES = 1_250_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PADS-1:0]       pad_valid,
    input  logic [NUM_PADS*BTN_W-1:0] pad_buttons,
    output logic                      axiov,
    output logic [DATA_SIZE-1:0]      axiod,
    output logic [7:0]                seq,
    output logic [15:0]               frames_sent
);

    localparam int CNT_MAX = (FRAME_WORDS > GAP_CYCLES) ? FRAME_WORDS : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] WORD_LAST = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    tx_state_t                 state;
    logic [CW-1:0]             cnt;      // word index in SEND, gap count in GAP
    logic [NUM_PADS*BTN_W-1:0] latest;
    logic [NUM_PADS*BTN_W-1:0] sent;
    logic                      pending;
    logic                      change;
    logic                      ka_expire;
    logic                      ka_clear;
    logic                      trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latest <= '0;
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (pad_valid[i]) begin
                    latest[i*BTN_W +: BTN_W] <= pad_buttons[i*BTN_W +: BTN_W];
                end
            end
        end
    end

    assign change   = (latest != sent);
    assign trigger  = change || ka_expire;
    assign ka_clear = (state == IDLE) && (trigger || pending);

    keepalive_timer #(
        .KEEPALIVE_CYCLES(KEEPALIVE_CYCLES)
    ) u_keepalive (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == IDLE),
        .clear (ka_clear),
        .expire(ka_expire)
    );

    // axiod is precomputed one word ahead so the stream comes straight from
    // registers; sent is only written on SEND entry, which freezes the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sent        <= '0;
            pending     <= 1'b0;
            seq         <= '0;
            frames_sent <= '0;
            axiov       <= 1'b0;
            axiod       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        state   <= SEND;
                        cnt     <= '0;
                        sent    <= latest;
                        pending <= 1'b0;
                        seq     <= seq + 8'd1;
                        axiov   <= 1'b1;
                        axiod   <= DATA_SIZE'(frame_word(0, seq + 8'd1, 256'(latest),
                                                         NUM_PADS, BTN_W));
                    end
                end
                SEND: begin
                    if (trigger) begin
                        pending <= 1'b1;
                    end
                    if (cnt == WORD_LAST) begin
                        state       <= GAP;
                        cnt         <= '0;
                        axiov       <= 1'b0;
                        axiod       <= '0;
                        frames_sent <= frames_sent + 16'd1;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        axiod <= DATA_SIZE'(frame_word(int'(cnt) + 1, seq, 256'(sent),
                                                       NUM_PADS, BTN_W));
                    end
                end
                GAP: begin
                    if (trigger) begin
                        pending <= 1'b1;
                    end
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    axiov <= 1'b0;
                    axiod <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_tx_framer.sv
// tb/tb_button_tx_framer.sv - directed self-checking bench for button_tx_framer
module tb_button_tx_framer;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // dut_a: keepalive disabled; dut_b: keepalive of 100 cycles
    logic        a_rstn, b_rstn;
    logic [1:0]  a_pv, b_pv;
    logic [15:0] a_pb, b_pb;
    logic        a_v, b_v;
    logic [15:0] a_d, b_d;
    logic [7:0]  a_seq, b_seq;
    logic [15:0] a_fs, b_fs;

    logic        sel_b = 1'b0;
    logic        mon_v;
    logic [15:0] mon_d;

    logic [15:0] words [32];
    int          f_start, f_last, f_len;
    logic        f_ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mon_v = sel_b ? b_v : a_v;
    assign mon_d = sel_b ? b_d : a_d;

    button_tx_framer #(.KEEPALIVE_CYCLES(0)) dut_a (
        .clk(clk), .rst_n(a_rstn), .pad_valid(a_pv), .pad_buttons(a_pb),
        .axiov(a_v), .axiod(a_d), .seq(a_seq), .frames_sent(a_fs)
    );

    button_tx_framer #(.KEEPALIVE_CYCLES(100)) dut_b (
        .clk(clk), .rst_n(b_rstn), .pad_valid(b_pv), .pad_buttons(b_pb),
        .axiov(b_v), .axiod(b_d), .seq(b_seq), .frames_sent(b_fs)
    );

    // Waits up to budget cycles for a frame on the selected DUT and records it.
    // Optionally strobes dut_a pads while word inj_word is on the bus.
    task automatic capture_frame(input int budget, input int inj_word,
                                 input logic [1:0] inj_pv, input logic [15:0] inj_pb);
        f_ok  = 1'b0;
        f_len = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mon_v) begin
                f_ok = 1'b1;
                break;
            end
        end
        if (!f_ok) return;
        f_start = cyc;
        while (mon_v && f_len < 40) begin
            if (f_len < 32) words[f_len] = mon_d;
            if (f_len == inj_word) begin
                a_pv = inj_pv;
                a_pb = inj_pb;
            end else begin
                a_pv = 2'b00;
            end
            f_len++;
            @(negedge clk);
        end
        a_pv   = 2'b00;
        f_last = f_start + f_len - 1;
    endtask

    task automatic test_reset();
        int highs;
        a_rstn = 1'b0;
        b_rstn = 1'b0;
        a_pv = '0; a_pb = '0; b_pv = '0; b_pb = '0;
        repeat (3) @(negedge clk);
        a_rstn = 1'b1;
        n_cmp++;
        if (a_v !== 1'b0 || a_d !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h expected v=0 d=0000", a_v, a_d);
        end
        n_cmp++;
        if (a_seq !== 8'd0 || a_fs !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counters: got seq=%0d fs=%0d expected 0/0", a_seq, a_fs);
        end
        highs = 0;
        repeat (10000) begin
            @(negedge clk);
            if (a_v !== 1'b0) highs++;
        end
        n_cmp++;
        if (highs != 0) begin
            n_err++;
            $display("FAIL idle_no_frame: got %0d valid cycles expected 0", highs);
        end
        n_cmp++;
        if (a_seq !== 8'd0) begin
            n_err++;
            $display("FAIL idle_seq: got %0d expected 0", a_seq);
        end
    endtask

    task automatic test_single_frame();
        int t;
        logic [15:0] exp_w;
        t = cyc;
        a_pv = 2'b10;
        a_pb = 16'h4100;
        @(negedge clk);
        a_pv = 2'b00;
        capture_frame(10, -1, 2'b00, 16'h0000);
        n_cmp++;
        if (!f_ok) begin
            n_err++;
            $display("FAIL single_present: got no frame expected frame");
            return;
        end
        n_cmp++;
        if (f_start != t + 2) begin
            n_err++;
            $display("FAIL single_latency: got start %0d expected %0d", f_start, t + 2);
        end
        n_cmp++;
        if (f_len != 32) begin
            n_err++;
            $display("FAIL single_length: got %0d expected 32", f_len);
        end
        for (int w = 0; w < 32; w++) begin
            exp_w = (w == 0) ? 16'hB701 : (w == 2) ? 16'h0141 : 16'h0000;
            n_cmp++;
            if (words[w] !== exp_w) begin
                n_err++;
                $display("FAIL single_word%0d: got %h expected %h", w, words[w], exp_w);
            end
        end
        n_cmp++;
        if (a_fs !== 16'd1 || a_seq !== 8'd1) begin
            n_err++;
            $display("FAIL single_counts: got fs=%0d seq=%0d expected 1/1", a_fs, a_seq);
        end
    endtask

    task automatic test_follow_up();
        int last1;
        @(negedge clk);
        a_rstn = 1'b0;
        repeat (2) @(negedge clk);
        a_rstn = 1'b1;
        @(negedge clk);
        a_pv = 2'b01;
        a_pb = 16'h0001;
        @(negedge clk);
        a_pv = 2'b00;
        capture_frame(10, 5, 2'b01, 16'h0003);
        n_cmp++;
        if (!f_ok || words[0] !== 16'hB701 || words[1] !== 16'h0001) begin
            n_err++;
            $display("FAIL follow_first: got ok=%b w0=%h w1=%h expected 1/B701/0001",
                     f_ok, words[0], words[1]);
        end
        last1 = f_last;
        capture_frame(200, -1, 2'b00, 16'h0000);
        n_cmp++;
        if (!f_ok || f_start != last1 + 66) begin
            n_err++;
            $display("FAIL follow_start: got ok=%b start=%0d expected start=%0d",
                     f_ok, f_start, last1 + 66);
        end
        n_cmp++;
        if (words[0] !== 16'hB702 || words[1] !== 16'h0003 || f_len != 32) begin
            n_err++;
            $display("FAIL follow_words: got w0=%h w1=%h len=%0d expected B702/0003/32",
                     words[0], words[1], f_len);
        end
        capture_frame(300, -1, 2'b00, 16'h0000);
        n_cmp++;
        if (f_ok !== 1'b0) begin
            n_err++;
            $display("FAIL follow_no_third: got extra frame at %0d expected none", f_start);
        end
        n_cmp++;
        if (a_fs !== 16'd2 || a_seq !== 8'd2) begin
            n_err++;
            $display("FAIL follow_counts: got fs=%0d seq=%0d expected 2/2", a_fs, a_seq);
        end
    endtask

    task automatic test_reset_midframe();
        logic seen;
        int highs;
        seen = 1'b0;
        a_pv = 2'b10;
        a_pb = 16'h0500;
        @(negedge clk);
        a_pv = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_v) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (!seen || a_v !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_word10: got seen=%b v=%b expected 1/1", seen, a_v);
        end
        #1 a_rstn = 1'b0;
        #1;
        n_cmp++;
        if (a_v !== 1'b0 || a_d !== 16'h0000) begin
            n_err++;
            $display("FAIL midreset_drop: got v=%b d=%h expected 0/0000", a_v, a_d);
        end
        repeat (2) @(negedge clk);
        a_rstn = 1'b1;
        highs = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_v !== 1'b0) highs++;
        end
        n_cmp++;
        if (highs != 0 || a_fs !== 16'd0 || a_seq !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_after: got valid=%0d fs=%0d seq=%0d expected 0/0/0",
                     highs, a_fs, a_seq);
        end
    endtask

    task automatic test_keepalive();
        int rel, prev, exp_start;
        logic [15:0] exp_w;
        sel_b = 1'b1;
        @(negedge clk);
        b_rstn = 1'b1;
        rel = cyc;
        prev = 0;
        for (int k = 1; k <= 257; k++) begin
            capture_frame(300, -1, 2'b00, 16'h0000);
            exp_start = (k == 1) ? rel + 100 : prev + 196;
            n_cmp++;
            if (!f_ok || f_start != exp_start || f_len != 32) begin
                n_err++;
                $display("FAIL ka_start%0d: got ok=%b start=%0d len=%0d expected start=%0d len=32",
                         k, f_ok, f_start, f_len, exp_start);
                return;
            end
            prev = f_start;
            for (int w = 0; w < 32; w++) begin
                exp_w = (w == 0) ? {8'hB7, 8'(k)} : (w == 2) ? 16'h0100 : 16'h0000;
                n_cmp++;
                if (words[w] !== exp_w) begin
                    n_err++;
                    $display("FAIL ka_frame%0d_word%0d: got %h expected %h",
                             k, w, words[w], exp_w);
                end
            end
            n_cmp++;
            if (b_seq !== 8'(k)) begin
                n_err++;
                $display("FAIL ka_seq%0d: got %0d expected %0d", k, b_seq, k % 256);
            end
        end
        n_cmp++;
        if (b_fs !== 16'd257) begin
            n_err++;
            $display("FAIL ka_frames_sent: got %0d expected 257", b_fs);
        end
    endtask

    task automatic test_simultaneous();
        int rel, first;
        sel_b = 1'b1;
        @(negedge clk);
        b_rstn = 1'b0;
        repeat (2) @(negedge clk);
        b_rstn = 1'b1;
        rel = cyc;
        repeat (98) @(negedge clk);
        b_pv = 2'b10;
        b_pb = 16'h2200;
        @(negedge clk);
        b_pv = 2'b00;
        capture_frame(10, -1, 2'b00, 16'h0000);
        n_cmp++;
        if (!f_ok || f_start != rel + 100) begin
            n_err++;
            $display("FAIL simul_start: got ok=%b start=%0d expected %0d", f_ok, f_start, rel + 100);
        end
        n_cmp++;
        if (words[0] !== 16'hB701 || words[2] !== 16'h0122) begin
            n_err++;
            $display("FAIL simul_words: got w0=%h w2=%h expected B701/0122", words[0], words[2]);
        end
        n_cmp++;
        if (b_fs !== 16'd1) begin
            n_err++;
            $display("FAIL simul_count: got %0d expected 1", b_fs);
        end
        first = f_start;
        capture_frame(300, -1, 2'b00, 16'h0000);
        n_cmp++;
        if (!f_ok || f_start != first + 196 || words[0] !== 16'hB702) begin
            n_err++;
            $display("FAIL simul_next: got ok=%b start=%0d w0=%h expected start=%0d w0=B702",
                     f_ok, f_start, words[0], first + 196);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_follow_up();
        test_reset_midframe();
        test_keepalive();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
